single_argmax_seq: RTL
======================

SINGLE_ARGMAX_SEQ -- requirements
Module: single_argmax_seq

Interface
REQ-001 SHALL have parameter IDX_W, default 8, meaning element-index width (max vector length 2^IDX_W).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  begin new vector; sampled only in IDLE.
REQ-005 SHALL have port len  input  IDX_W  element count minus one, captured on accepted start.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data.
REQ-008 SHALL have port in_data  input  32  IEEE-754 single element.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_max  output  32  maximum element bits.
REQ-012 SHALL have port out_idx  output  IDX_W  index of maximum, first element = 0.
REQ-013 SHALL have port busy  output  1  high in any state except IDLE.
REQ-014 SHALL have port nan_seen  output  1  vector contained NaN (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, FIRST, RUN, DONE.
REQ-016 IDLE: start=1 -> FIRST, capture len, clear count; start otherwise ignored (in FIRST/RUN/DONE).
REQ-017 Element accepted only on in_valid & in_ready; in_ready=1 exactly in FIRST and RUN.
REQ-018 FIRST: accepted element loads max register unconditionally, idx=0, count=1; -> DONE if len=0, else -> RUN.
REQ-019 RUN: each accepted element compared to max register; replace max and idx=count only if strictly greater; count increments.
REQ-020 Ordering SHALL be: differing signs -> positive wins (+0 > -0); both positive -> larger {exp,mant} wins; both negative -> smaller {exp,mant} wins; equal bits -> no replace (earliest index wins).
REQ-021 RUN: accept with count==len -> DONE next cycle, including that element's compare result.
REQ-022 DONE: out_valid=1, out_max/out_idx stable; out_ready=1 -> IDLE next cycle, out_valid low.
REQ-023 Latency: out_valid rises the cycle after the last element is accepted; with in_valid held high, vector of len+1 elements completes in len+2 cycles from FIRST entry.
REQ-024 in_valid gaps (stall) SHALL hold all state; no timeout.
REQ-025 count width IDX_W; len=2^IDX_W-1 SHALL complete without count wrap affecting termination.
REQ-026 out_max/out_idx SHALL retain last result in IDLE until the next FIRST accept.

Reset
REQ-027 rst=1 SHALL asynchronously force IDLE, in_ready=0, out_valid=0, busy=0, out_max=0, out_idx=0, count=0, nan_seen=0.
REQ-028 rst mid-vector SHALL abandon the vector; no partial result emitted; first post-reset start begins a fresh vector.

Configuration
REQ-029 Macro SINGLE_ARGMAX_NAN_EN defined: element with exp=0xFF and mant!=0 SHALL never replace max (unless it is the only accepted element so far -- then any later non-NaN replaces it), and SHALL set nan_seen, cleared on next FIRST accept.
REQ-030 SINGLE_ARGMAX_NAN_EN undefined: NaNs ordered by raw bits per REQ-020; nan_seen tied 0.

Verification
REQ-031 len=3, data 0x3F800000,0x40400000,0xC0000000,0x40400000 -> out_max=0x40400000, out_idx=1.
REQ-032 len=1, data 0xBF800000,0xC0000000 -> out_max=0xBF800000, out_idx=0; len=1, data 0x80000000,0x00000000 -> out_max=0x00000000, out_idx=1.
REQ-033 len=0, data 0x12345678, out_ready low 5 cycles -> out_valid held 5 cycles with stable outputs, IDLE cycle after out_ready.
REQ-034 len=4, in_valid toggled every other cycle, start pulsed during RUN -> start ignored, result identical to unstalled run.
REQ-035 rst asserted after 2 of 4 elements -> all outputs zero immediately; new start len=0 data 0x3F800000 -> out_max=0x3F800000, out_idx=0.
REQ-036 With SINGLE_ARGMAX_NAN_EN, len=2, data 0x7FC00000,0x3F800000,0x7F800001 -> out_max=0x3F800000, out_idx=1, nan_seen=1.

Source files
------------

// File: rtl/single_argmax_seq.sv
// Sequential argmax over a stream of IEEE-754 singles: reports the largest element and its first index.
// Optional NaN handling (NaNs never win, nan_seen flag) is enabled by defining SINGLE_ARGMAX_NAN_EN.
module single_argmax_seq #(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic             busy,
  output logic             nan_seen
);

  typedef enum logic [1:0] {IDLE, FIRST, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      max_q, max_d;
  logic             accept;
  logic             replace;

  // Strict float ordering on raw bits: +0 beats -0, negatives compare reversed.
  function automatic logic greater(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return ~a[31];
    else if (!a[31])    return a[30:0] > b[30:0];
    else                return a[30:0] < b[30:0];
  endfunction

`ifdef SINGLE_ARGMAX_NAN_EN
  function automatic logic is_nan(input logic [31:0] a);
    return (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  endfunction
`endif

  assign accept = in_valid & in_ready;

  always_comb begin
    replace = greater(in_data, max_q);
`ifdef SINGLE_ARGMAX_NAN_EN
    // A NaN max can only come from leading NaNs, so any real number displaces it.
    if (is_nan(in_data))     replace = 1'b0;
    else if (is_nan(max_q))  replace = 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    idx_d   = idx_q;
    max_d   = max_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FIRST;
          len_d   = len;
          count_d = '0;
        end
      end
      FIRST: begin
        if (accept) begin
          max_d   = in_data;
          idx_d   = '0;
          count_d = IDX_W'(1);
          state_d = (len_q == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          if (replace) begin
            max_d = in_data;
            idx_d = count_q;
          end
          count_d = count_q + IDX_W'(1);
          // Termination uses the pre-increment count, so a full-length vector's wrap is harmless.
          if (count_q == len_q) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      count_q <= '0;
      idx_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      max_q   <= max_d;
    end
  end

`ifdef SINGLE_ARGMAX_NAN_EN
  logic nan_q, nan_d;

  always_comb begin
    nan_d = nan_q;
    if (accept && state_q == FIRST)    nan_d = is_nan(in_data);
    else if (accept && state_q == RUN) nan_d = nan_q | is_nan(in_data);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) nan_q <= 1'b0;
    else     nan_q <= nan_d;
  end

  assign nan_seen = nan_q;
`else
  assign nan_seen = 1'b0;
`endif

  assign in_ready  = (state_q == FIRST) || (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_max   = max_q;
  assign out_idx   = idx_q;

endmodule
